m_a_func: RTL and testbench



---
 rtl/m_a_func.sv | 80 ++++++++
 tb/tb_m_a_func.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/m_a_func.sv
// m_a_func: two fixed 3-input Boolean functions of {x1,x2,x3}, offered both
// combinationally and as registered copies, plus a saturating z1 hit counter.
module m_a_func #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x1,
   input  logic             x2,
   input  logic             x3,
   input  logic             cnt_clr,
   output logic             z1,
   output logic             z2,
   output logic             z1_r,
   output logic             z2_r,
   output logic             vld_r,
   output logic [CNT_W-1:0] z1_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       idx_s;
   logic             z1_s;
   logic             z2_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   assign idx_s = {x1, x2, x3};

   // Truth table lookup for both functions; clock and reset play no part here.
   always_comb begin
      z1_s = 1'b0;
      z2_s = 1'b0;
      case (idx_s)
         3'b000:  begin z1_s = 1'b0; z2_s = 1'b0; end
         3'b001:  begin z1_s = 1'b1; z2_s = 1'b0; end
         3'b010:  begin z1_s = 1'b1; z2_s = 1'b0; end
         3'b011:  begin z1_s = 1'b0; z2_s = 1'b1; end
         3'b100:  begin z1_s = 1'b1; z2_s = 1'b0; end
         3'b101:  begin z1_s = 1'b1; z2_s = 1'b1; end
         3'b110:  begin z1_s = 1'b0; z2_s = 1'b1; end
         3'b111:  begin z1_s = 1'b1; z2_s = 1'b1; end
         default: begin z1_s = 1'bx; z2_s = 1'bx; end
      endcase
   end

   assign z1 = z1_s;
   assign z2 = z2_s;

   // Next counter value: clear wins over increment, increment stops at all-ones.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (cnt_clr) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (z1_s && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Registered copies, valid flag and hit counter with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z1_r  <= 1'b0;
         z2_r  <= 1'b0;
         vld_r <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         z1_r  <= z1_s;
         z2_r  <= z2_s;
         vld_r <= 1'b1;
         cnt_r <= cnt_nxt_s;
      end
   end

   assign z1_cnt = cnt_r;

endmodule

// File: tb/tb_m_a_func.sv
// Directed self-checking bench for m_a_func: combinational table, registered
// path, asynchronous reset, counter saturation, clear priority and no-count hold.
module tb_m_a_func;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       x1, x2, x3;
   logic       cnt_clr;
   logic       z1, z2, z1_r, z2_r, vld_r;
   logic [7:0] z1_cnt;

   int errors;
   int checks;

   // Expected function values indexed by {x1,x2,x3}
   logic [7:0] exp_z1_tab;
   logic [7:0] exp_z2_tab;

   m_a_func #(.CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .x1      (x1),
      .x2      (x2),
      .x3      (x3),
      .cnt_clr (cnt_clr),
      .z1      (z1),
      .z2      (z2),
      .z1_r    (z1_r),
      .z2_r    (z2_r),
      .vld_r   (vld_r),
      .z1_cnt  (z1_cnt)
   );

   // Gated clock so the combinational test can run with clk held low.
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
      else        clk = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_x(input logic [2:0] v);
      {x1, x2, x3} = v;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      exp_z1_tab = 8'b1011_0110;
      exp_z2_tab = 8'b1110_1000;
      clk_en     = 1'b0;
      rst_n      = 1'b0;
      cnt_clr    = 1'b0;
      set_x(3'b000);
      #2;

      // Reset state with clock idle
      check("rst_z1_r",  32'(z1_r),   32'd0);
      check("rst_z2_r",  32'(z2_r),   32'd0);
      check("rst_vld_r", 32'(vld_r),  32'd0);
      check("rst_cnt",   32'(z1_cnt), 32'd0);

      // Exhaustive combinational table, clk idle, rst_n held
      for (int i = 0; i < 8; i++) begin
         set_x(3'(i));
         #10;
         check($sformatf("comb_z1_%0d", i), 32'(z1), 32'(exp_z1_tab[i]));
         check($sformatf("comb_z2_%0d", i), 32'(z2), 32'(exp_z2_tab[i]));
      end

      // Registered path: release reset between edges, drive 101 then 011
      clk_en = 1'b1;
      @(negedge clk);
      set_x(3'b101);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reg1_z1_r",  32'(z1_r),   32'd1);
      check("reg1_z2_r",  32'(z2_r),   32'd1);
      check("reg1_vld_r", 32'(vld_r),  32'd1);
      check("reg1_cnt",   32'(z1_cnt), 32'd1);
      set_x(3'b011);
      @(posedge clk); #1;
      check("reg2_z1_r",  32'(z1_r),   32'd0);
      check("reg2_z2_r",  32'(z2_r),   32'd1);
      check("reg2_vld_r", 32'(vld_r),  32'd1);
      check("reg2_cnt",   32'(z1_cnt), 32'd1);

      // Build up z1_r = 1, z1_cnt = 5, then assert reset between edges
      set_x(3'b001);
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_z1_r", 32'(z1_r),   32'd1);
      check("pre_rst_cnt",  32'(z1_cnt), 32'd5);
      @(negedge clk);
      set_x(3'b011);
      rst_n = 1'b0;
      #1;
      check("arst_z1_r",  32'(z1_r),   32'd0);
      check("arst_z2_r",  32'(z2_r),   32'd0);
      check("arst_vld_r", 32'(vld_r),  32'd0);
      check("arst_cnt",   32'(z1_cnt), 32'd0);
      check("arst_z1",    32'(z1),     32'd0);
      check("arst_z2",    32'(z2),     32'd1);
      set_x(3'b100);
      #1;
      check("arst_trk_z1", 32'(z1), 32'd1);
      check("arst_trk_z2", 32'(z2), 32'd0);
      @(posedge clk); #1;
      check("arst_hold_vld", 32'(vld_r),  32'd0);
      check("arst_hold_cnt", 32'(z1_cnt), 32'd0);
      check("arst_hold_z1r", 32'(z1_r),   32'd0);

      // Saturation: hold 001 for 300 edges after release
      @(negedge clk);
      set_x(3'b001);
      rst_n = 1'b1;
      repeat (255) @(posedge clk);
      #1;
      check("sat_255", 32'(z1_cnt), 32'd255);
      repeat (45) @(posedge clk);
      #1;
      check("sat_300", 32'(z1_cnt), 32'd255);

      // Clear, count to 10, then clear with 111 present
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      check("clr_a", 32'(z1_cnt), 32'd0);
      cnt_clr = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("cnt_10", 32'(z1_cnt), 32'd10);
      set_x(3'b111);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      check("clr_prio", 32'(z1_cnt), 32'd0);
      cnt_clr = 1'b0;
      @(posedge clk); #1;
      check("clr_then_inc", 32'(z1_cnt), 32'd1);

      // No-count: 110 gives z1 = 0, z2 = 1 for 20 edges
      set_x(3'b110);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check($sformatf("nocnt_cnt_%0d", i),  32'(z1_cnt), 32'd1);
         check($sformatf("nocnt_z2r_%0d", i),  32'(z2_r),   32'd1);
      end
      check("nocnt_z1r", 32'(z1_r), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
